// File: rtl/hazard_scoreboard_unit.sv
// ID-stage hazard/forwarding unit with a register scoreboard for one multi-cycle MUL/DIV unit.
// Define HAZ_PERF_CNT_EN to implement the stall_cnt / md_stall_cnt performance counters.
module hazard_scoreboard_unit #(
    parameter int unsigned REG_AW  = 5,
    parameter int unsigned NUM_SRC = 2,
    parameter int unsigned MD_LAT  = 4,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        id_valid,
    input  logic [NUM_SRC*REG_AW-1:0]   id_src_id,
    input  logic [NUM_SRC-1:0]          id_src_used,
    input  logic [REG_AW-1:0]           id_dst_id,
    input  logic                        id_wr_reg,
    input  logic                        id_is_md,
    input  logic                        e_wr_reg,
    input  logic                        e_mem_to_reg,
    input  logic [REG_AW-1:0]           e_dst_id,
    input  logic                        m_wr_reg,
    input  logic                        m_mem_to_reg,
    input  logic [REG_AW-1:0]           m_dst_id,
    output logic [2*NUM_SRC-1:0]        fwd_sel,
    output logic                        no_stall,
    output logic                        md_busy,
    output logic                        md_wb_valid,
    output logic [REG_AW-1:0]           md_wb_id,
    output logic [CNT_W-1:0]            stall_cnt,
    output logic [CNT_W-1:0]            md_stall_cnt
);

    localparam int unsigned NREG  = 1 << REG_AW;
    localparam int unsigned LAT_W = $clog2(MD_LAT + 1);

    logic [NREG-1:0]   pending_q, pending_d;
    logic [LAT_W-1:0]  md_cnt_q, md_cnt_d;
    logic [REG_AW-1:0] md_wb_id_q, md_wb_id_d;

    logic [REG_AW-1:0] src;
    logic              load_use, raw_hit, waw_hit, struct_hit, md_term, md_issue;

    assign md_busy     = (md_cnt_q != '0);
    assign md_wb_valid = (md_cnt_q == LAT_W'(1));
    assign md_wb_id    = md_wb_id_q;

    always_comb begin
        fwd_sel  = '0;
        src      = '0;
        load_use = 1'b0;
        raw_hit  = 1'b0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            src = id_src_id[k*REG_AW +: REG_AW];
            if (src != '0) begin
                // An EXE load has no data yet, so it falls through to the MEM check.
                if (e_wr_reg && !e_mem_to_reg && (e_dst_id == src)) begin
                    fwd_sel[2*k +: 2] = 2'b01;
                end else if (m_wr_reg && (m_dst_id == src)) begin
                    fwd_sel[2*k +: 2] = m_mem_to_reg ? 2'b11 : 2'b10;
                end
                if (id_src_used[k]) begin
                    if (e_wr_reg && e_mem_to_reg && (e_dst_id == src)) begin
                        load_use = 1'b1;
                    end
                    if (pending_q[src]) begin
                        raw_hit = 1'b1;
                    end
                end
            end
        end
        waw_hit    = id_wr_reg && (id_dst_id != '0) && pending_q[id_dst_id];
        struct_hit = id_is_md && md_busy;
        md_term    = id_valid && (raw_hit || waw_hit || struct_hit);
        no_stall   = !(md_term || (id_valid && load_use));
        md_issue   = id_valid && id_is_md && no_stall && (id_dst_id != '0);
    end

    always_comb begin
        pending_d  = pending_q;
        md_cnt_d   = md_cnt_q;
        md_wb_id_d = md_wb_id_q;
        if (md_busy) begin
            md_cnt_d = md_cnt_q - LAT_W'(1);
        end
        if (md_wb_valid) begin
            pending_d[md_wb_id_q] = 1'b0;
        end
        // Issue is refused while busy, so it never collides with the write-back clear.
        if (md_issue) begin
            pending_d[id_dst_id] = 1'b1;
            md_wb_id_d           = id_dst_id;
            md_cnt_d             = LAT_W'(MD_LAT);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q  <= '0;
            md_cnt_q   <= '0;
            md_wb_id_q <= '0;
        end else begin
            pending_q  <= pending_d;
            md_cnt_q   <= md_cnt_d;
            md_wb_id_q <= md_wb_id_d;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, md_stall_cnt_q, md_stall_cnt_d;

    always_comb begin
        stall_cnt_d    = stall_cnt_q;
        md_stall_cnt_d = md_stall_cnt_q;
        if (id_valid && !no_stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (md_term && (md_stall_cnt_q != '1)) begin
            md_stall_cnt_d = md_stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q    <= '0;
            md_stall_cnt_q <= '0;
        end else begin
            stall_cnt_q    <= stall_cnt_d;
            md_stall_cnt_q <= md_stall_cnt_d;
        end
    end

    assign stall_cnt    = stall_cnt_q;
    assign md_stall_cnt = md_stall_cnt_q;
`else
    assign stall_cnt    = '0;
    assign md_stall_cnt = '0;
`endif

endmodule
